// File: rtl/pe_psum_acc.sv
// Sums cfg_len adder-tree beats into one wrapped 32-bit result; out_vld rises 1 cycle after the last beat.
// Input stalls freely via in_vld; the result holds stable in OUT until out_rdy.
module pe_psum_acc #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] acc;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] sum;
  logic              accept;
  logic              last;
  logic              ovf_step;

  assign in_rdy  = (state == ACC);
  assign out_vld = (state == OUT);
  assign busy    = (state != IDLE);

  assign accept = in_vld & in_rdy;
  assign sum    = acc + in_data;
  assign last   = (cnt == len_q - LEN_W'(1));
  // Signed overflow: same-sign operands producing a result of the other sign.
  assign ovf_step = (acc[DATA_W-1] == in_data[DATA_W-1]) &&
                    (sum[DATA_W-1] != acc[DATA_W-1]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_len == '0) ? OUT : ACC;
      ACC:     if (accept && last) state_nxt = OUT;
      OUT:     if (out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            out_ovf <= 1'b0;
            if (cfg_len != '0) begin
              len_q <= cfg_len;
              acc   <= '0;
              cnt   <= '0;
            end else begin
              out_data <= '0;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc <= sum;
            cnt <= cnt + LEN_W'(1);
            if (ovf_step) out_ovf <= 1'b1;
            if (last) out_data <= sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pe_psum_acc.md
Name: pe_psum_acc

Overview:
- Sequential partial-sum accumulator that sits directly downstream of the PE add tree.
- Consumes one 32-bit adder-tree result per beat, one beat per 32-element K-slice, and sums a configured number of beats into one output element.
- Presents the finished sum on a valid/ready output port to the writeback stage.
- Arithmetic wraps modulo 2^32, the same as the add tree; signed overflow is reported on a sticky flag.

Parameters:
- DATA_W, 32: width of input beat, accumulator and result.
- LEN_W, 16: width of the beat-count configuration.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  job start pulse; sampled only in IDLE.
- cfg_len  input  LEN_W  beats per job; sampled with start.
- in_vld  input  1  input beat valid.
- in_rdy  output  1  input beat ready.
- in_data  input  DATA_W  adder-tree result (two's complement).
- out_vld  output  1  result valid.
- out_rdy  input  1  result ready from downstream.
- out_data  output  DATA_W  accumulated result.
- out_ovf  output  1  sticky signed-overflow flag for the current or last job.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- One clock domain. Reset is synchronous and active-low on rst_n; clocks are named clk, resets rst_n.
- Reset values: state=IDLE, acc=0, cnt=0, len_q=0, in_rdy=0, out_vld=0, out_data=0, out_ovf=0, busy=0.
- Reset mid-job discards all progress and returns to IDLE with the values above.
- States are IDLE, ACC and OUT.
- IDLE, start=1, cfg_len!=0:
  - latch len_q=cfg_len; clear acc, cnt and out_ovf.
  - go to ACC.
- IDLE, start=1, cfg_len==0:
  - clear out_ovf and set out_data=0.
  - go to OUT with out_vld=1 on the next cycle.
- start outside IDLE is ignored, including a cycle where an OUT handshake completes.
- ACC:
  - in_rdy=1, decoded combinationally from state; in_rdy=0 in every other state.
  - A beat is accepted when in_vld & in_rdy.
  - On accept: acc <= acc + in_data, truncated to DATA_W.
  - Set out_ovf if both operands have the same sign bit and the sum's sign differs; out_ovf never clears within a job.
  - cnt increments per accepted beat; cycles with in_vld=0 change nothing.
- Last beat (accepted beat with cnt==len_q-1):
  - out_data <= acc + in_data, including that beat's ovf update.
  - out_vld=1 and state=OUT from the next cycle.
  - Latency: out_vld rises exactly 1 cycle after the last beat is accepted.
- OUT:
  - out_vld held high; out_data and out_ovf held stable until out_vld & out_rdy.
  - On the handshake: out_vld=0 next cycle, state=IDLE.
  - out_data and out_ovf keep their values until the next job updates them.
- Throughput: the earliest next start is accepted the cycle after returning to IDLE, so a job occupies len_q + 2 cycles minimum.
- cnt is LEN_W bits and never wraps, because len_q ≤ 2^LEN_W-1.
- in_data is not sampled when in_rdy=0.
- busy = (state != IDLE).

Test Plan:
- Basic sum: start with cfg_len=4; in_data 1,2,3,4 on consecutive cycles with in_vld=1 and out_rdy=1.
  -> out_data=10, out_ovf=0; out_vld high 1 cycle after the 4th beat, for 1 cycle; busy low the following cycle.
- Negative values, stalls and backpressure: cfg_len=3; beats 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD with 2-cycle in_vld gaps; out_rdy low for 5 cycles after out_vld.
  -> out_data=0xFFFFFFFA held stable with out_vld high for 6 cycles; drops after the handshake.
- Overflow wrap: cfg_len=3; beats 0x7FFFFFFF, 0x00000001, 0xFFFFFFFF.
  -> out_data=0x7FFFFFFF, out_ovf=1 (sticky despite the later in-range sum).
- Zero length: start with cfg_len=0 at cycle t.
  -> out_vld=1 at t+1 with out_data=0 and out_ovf=0; in_rdy never asserts.
- Ignored start and mid-job reset: cfg_len=4.
  - Pulse start with cfg_len=1 after 2 beats -> ignored; the job still needs 4 beats and sums correctly.
  - Repeat, asserting rst_n=0 for 1 cycle after 2 beats -> all outputs return to reset values; a fresh job with 5,6 (cfg_len=2) gives 11.
- Back-to-back jobs: out_rdy=1; start pulsed on the first IDLE cycle after each result; jobs of cfg_len 2 ({3,4}) then 2 ({10,20}).
  -> results 7 then 30; the accumulator is cleared between jobs; no start is lost.
